// File: rtl/rv_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_mc_pkg
// Purpose  : Shared definitions for the multi-cycle RV32I control path.
//            Holds the main FSM state type, the base opcodes handled by the
//            controller and the datapath mux / ALUOp encodings. The ALUOp
//            encodings are also used by the ALU decoder, so they must not
//            change independently of it.
// Revision : 1.0 - initial release
// ============================================================================
package rv_mc_pkg;

    // Main control FSM states (4-bit encoding exposed on state_dbg).
    // Encodings 12..15 are unused and recover to S_FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    // Base opcodes (instruction[6:0])
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    // ALUOp, shared with the ALU decoder
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    // Result mux select
    localparam logic [1:0] c_res_aluout    = 2'b00;
    localparam logic [1:0] c_res_rdata     = 2'b01;
    localparam logic [1:0] c_res_aluresult = 2'b10;

    // ALU A operand select
    localparam logic [1:0] c_srca_pc    = 2'b00;
    localparam logic [1:0] c_srca_oldpc = 2'b01;
    localparam logic [1:0] c_srca_rd1   = 2'b10;

    // ALU B operand select
    localparam logic [1:0] c_srcb_rd2  = 2'b00;
    localparam logic [1:0] c_srcb_imm  = 2'b01;
    localparam logic [1:0] c_srcb_four = 2'b10;

    // Memory address select
    localparam logic c_adr_pc     = 1'b0;
    localparam logic c_adr_aluout = 1'b1;

endpackage : rv_mc_pkg
`default_nettype wire

// File: rtl/rv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv_multicycle_ctrl
// Purpose  : Main control FSM of the multi-cycle RV32I core. Sequences the
//            shared ALU, the unified instruction/data memory port, the IR
//            and the register file for lw, sw, R-type, I-type ALU, beq and
//            jal. Memory phases stall on mem_ready.
// Params   : TRAP_HOLD  1 = illegal opcode parks in TRAP until reset,
//                       0 = TRAP lasts one cycle, then FETCH
// Ports    : clk, rst_n                 clock, async active-low reset
//            opcode, zero, mem_ready    IR opcode, ALU zero, memory handshake
//            pc_write, ir_write,        register enables
//            reg_write, mem_write
//            adr_src, result_src,       datapath mux selects
//            alu_src_a, alu_src_b
//            alu_op                     ALUOp to the ALU decoder
//            illegal, retire            trap flag, instruction-complete pulse
//            state_dbg                  current state encoding
// Revision : 1.0 - initial release
// ============================================================================
module rv_multicycle_ctrl
    import rv_mc_pkg::*;
#(
    parameter bit TRAP_HOLD = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       illegal,
    output logic       retire,
    output logic [3:0] state_dbg
);

    state_t r_state;
    state_t w_next_state;

    // Raw (pre-reset-gating) decode of the current state
    logic       w_pc_update;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_illegal;
    logic       w_retire;
    logic       w_adr_src;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. opcode is only looked at in DECODE and MEMADR.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:    w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    c_op_load,
                    c_op_store:  w_next_state = S_MEMADR;
                    c_op_rtype:  w_next_state = S_EXECR;
                    c_op_itype:  w_next_state = S_EXECI;
                    c_op_branch: w_next_state = S_BEQ;
                    c_op_jal:    w_next_state = S_JAL;
                    default:     w_next_state = S_TRAP;
                endcase
            end
            // Loads and stores differ only in opcode bit 5
            S_MEMADR:   w_next_state = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next_state = S_ALUWB;
            S_EXECI:    w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BEQ:      w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
            S_TRAP:     w_next_state = TRAP_HOLD ? S_TRAP : S_FETCH;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Everything is a function of the state; the only
    // input qualifiers are mem_ready (FETCH, MEMWRITE) and zero (BEQ).
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        w_retire     = 1'b0;
        w_adr_src    = c_adr_pc;
        w_result_src = c_res_aluout;
        w_alu_src_a  = c_srca_pc;
        w_alu_src_b  = c_srcb_rd2;
        w_alu_op     = c_aluop_add;

        case (r_state)
            S_FETCH: begin
                // PC <= PC + 4 computed directly on ALUResult
                w_adr_src    = c_adr_pc;
                w_alu_src_a  = c_srca_pc;
                w_alu_src_b  = c_srcb_four;
                w_alu_op     = c_aluop_add;
                w_result_src = c_res_aluresult;
                w_ir_write   = mem_ready;
                w_pc_update  = mem_ready;
            end
            S_DECODE: begin
                // Speculative branch target OldPC + imm into ALUOut
                w_alu_src_a  = c_srca_oldpc;
                w_alu_src_b  = c_srcb_imm;
                w_alu_op     = c_aluop_add;
            end
            S_MEMADR: begin
                w_alu_src_a  = c_srca_rd1;
                w_alu_src_b  = c_srcb_imm;
                w_alu_op     = c_aluop_add;
            end
            S_MEMREAD: begin
                w_adr_src    = c_adr_aluout;
                w_result_src = c_res_aluout;
            end
            S_MEMWB: begin
                w_result_src = c_res_rdata;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
            end
            S_MEMWRITE: begin
                // Request held through the accepting cycle
                w_adr_src    = c_adr_aluout;
                w_result_src = c_res_aluout;
                w_mem_write  = 1'b1;
                w_retire     = mem_ready;
            end
            S_EXECR: begin
                w_alu_src_a  = c_srca_rd1;
                w_alu_src_b  = c_srcb_rd2;
                w_alu_op     = c_aluop_funct;
            end
            S_EXECI: begin
                w_alu_src_a  = c_srca_rd1;
                w_alu_src_b  = c_srcb_imm;
                w_alu_op     = c_aluop_funct;
            end
            S_ALUWB: begin
                w_result_src = c_res_aluout;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
            end
            S_BEQ: begin
                // Compare RD1 - RD2; PC takes ALUOut (target from DECODE)
                w_alu_src_a  = c_srca_rd1;
                w_alu_src_b  = c_srcb_rd2;
                w_alu_op     = c_aluop_sub;
                w_result_src = c_res_aluout;
                w_branch     = 1'b1;
                w_retire     = 1'b1;
            end
            S_JAL: begin
                // PC <= target (ALUOut) while ALU forms OldPC + 4 for rd
                w_alu_src_a  = c_srca_oldpc;
                w_alu_src_b  = c_srcb_four;
                w_alu_op     = c_aluop_add;
                w_result_src = c_res_aluout;
                w_pc_update  = 1'b1;
            end
            S_TRAP: begin
                w_illegal    = 1'b1;
            end
            default: begin
                // Unused encodings: all enables low, selects at 0
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. Enables are masked by rst_n so they drop the moment reset
    // asserts, without waiting for the state register to settle.
    // ------------------------------------------------------------------
    assign pc_write   = rst_n & (w_pc_update | (w_branch & zero));
    assign ir_write   = rst_n & w_ir_write;
    assign mem_write  = rst_n & w_mem_write;
    assign reg_write  = rst_n & w_reg_write;
    assign illegal    = rst_n & w_illegal;
    assign retire     = rst_n & w_retire;

    assign adr_src    = w_adr_src;
    assign result_src = w_result_src;
    assign alu_src_a  = w_alu_src_a;
    assign alu_src_b  = w_alu_src_b;
    assign alu_op     = w_alu_op;
    assign state_dbg  = r_state;

endmodule : rv_multicycle_ctrl
`default_nettype wire
